// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, default widths and state encodings
package uart_pkg;

  localparam int TICKS_PER_BIT     = 16;
  localparam int DEF_NB_STATE      = 3;
  localparam int DEF_NB_COUNT      = 4;
  localparam int DEF_NB_DATA_COUNT = 4;
  localparam int DEF_NB_DATA       = 8;
  localparam int DEF_N_STOP_BITS   = 2;

  typedef enum logic [DEF_NB_STATE-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/tx_uart.sv
// rtl/tx_uart.sv - UART transmitter, 16 ticks per bit, LSB first, registered line
// Optional even parity bit between data and stop bits when TX_PARITY_EN is defined.
module tx_uart
  import uart_pkg::*;
#(
  parameter int NB_STATE      = DEF_NB_STATE,
  parameter int NB_COUNT      = DEF_NB_COUNT,
  parameter int NB_DATA_COUNT = DEF_NB_DATA_COUNT,
  parameter int NB_DATA       = DEF_NB_DATA,
  parameter int N_STOP_BITS   = DEF_N_STOP_BITS
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done_tick,
  output logic               o_busy
);

  localparam logic [NB_STATE-1:0]      S_IDLE    = NB_STATE'(ST_IDLE);
  localparam logic [NB_STATE-1:0]      S_START   = NB_STATE'(ST_START);
  localparam logic [NB_STATE-1:0]      S_DATA    = NB_STATE'(ST_DATA);
  localparam logic [NB_STATE-1:0]      S_STOP    = NB_STATE'(ST_STOP);
`ifdef TX_PARITY_EN
  localparam logic [NB_STATE-1:0]      S_PARITY  = NB_STATE'(ST_PARITY);
`endif
  localparam logic [NB_COUNT-1:0]      TICK_LAST = NB_COUNT'(TICKS_PER_BIT - 1);
  localparam logic [NB_DATA_COUNT-1:0] DATA_LAST = NB_DATA_COUNT'(NB_DATA - 1);
  localparam logic [NB_DATA_COUNT-1:0] STOP_LAST = NB_DATA_COUNT'(N_STOP_BITS - 1);

  logic [NB_STATE-1:0]      state_q, state_d;
  logic [NB_COUNT-1:0]      tick_q, tick_d, tick_adv;
  logic [NB_DATA_COUNT-1:0] bitc_q, bitc_d;
  logic [NB_DATA-1:0]       shreg_q, shreg_d;
  logic                     tx_q, tx_d;
  logic                     done_q, done_d;
  logic                     bit_end;

`ifdef TX_PARITY_EN
  logic parity_q;

  // Parity is captured with the payload so later i_data changes cannot disturb it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      parity_q <= 1'b0;
    end else if (state_q == S_IDLE && i_tx_start) begin
      parity_q <= ^i_data;
    end
  end
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bitc_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bitc_q  <= bitc_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bit_end  = i_tick && (tick_q == TICK_LAST);
  assign tick_adv = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bitc_d  = bitc_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE && i_tick) begin
      tick_d = tick_adv;
    end
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_tx_start) begin
          shreg_d = i_data;
          tick_d  = '0;
          bitc_d  = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bitc_q == DATA_LAST) begin
            bitc_d = '0;
`ifdef TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bitc_d = bitc_q + 1'b1;
            tx_d   = shreg_d[0];
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bitc_q == STOP_LAST) begin
            bitc_d  = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bitc_d = bitc_q + 1'b1;
          end
        end
      end
      default: begin
        // Unused encodings (including PARITY when it is compiled out) fall back to idle.
        tx_d    = 1'b1;
        tick_d  = '0;
        bitc_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_tx           = tx_q;
  assign o_tx_done_tick = done_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_uart.sv
// tb/tb_tx_uart.sv - self-checking bench for tx_uart against a tick-count line model
module tb_tx_uart;

  localparam int NB_DATA = 8;
  localparam int N_STOP  = 2;
`ifdef TX_PARITY_EN
  localparam int N_BITS  = 1 + NB_DATA + 1 + N_STOP;
  localparam int CLK_D1  = 192;
  localparam int CLK_D2  = 384;
  localparam int CLK_D4  = 768;
`else
  localparam int N_BITS  = 1 + NB_DATA + N_STOP;
  localparam int CLK_D1  = 176;
  localparam int CLK_D2  = 352;
  localparam int CLK_D4  = 704;
`endif
  localparam int FRAME_TICKS = N_BITS * 16;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_tick = 1'b1;
  logic         i_tx_start = 1'b0;
  logic [7:0]   i_data = 8'h00;
  logic         o_tx, o_tx_done_tick, o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  tx_uart dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_tick(i_tick),
    .i_tx_start(i_tx_start),
    .i_data(i_data),
    .o_tx(o_tx),
    .o_tx_done_tick(o_tx_done_tick),
    .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line level after t ticks have elapsed since acceptance.
  function automatic logic exp_line(input logic [7:0] d, input int t);
    int b;
    b = t / 16;
    if (b == 0) return 1'b0;
    if (b <= NB_DATA) return d[b-1];
`ifdef TX_PARITY_EN
    if (b == NB_DATA + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Entered just after a negedge with i_tx_start/i_data set up; leaves in the done cycle.
  task automatic run_frame(input logic [7:0] d, input int div, input bit spur,
                           input bit nxt, input logic [7:0] nd, output int done_edge);
    int t;
    int n;
    bit tk;
    t = 0;
    n = 0;
    tk = 1'b0;
    done_edge = -1;
    @(posedge i_clock);
    forever begin
      @(negedge i_clock);
      check("tx_line", o_tx, exp_line(d, t));
      check("busy", o_busy, t < FRAME_TICKS);
      check("done_tick", o_tx_done_tick, t == FRAME_TICKS);
      if (t >= FRAME_TICKS) begin
        done_edge  = n;
        i_tx_start = nxt;
        i_data     = nd;
        i_tick     = 1'b1;
        break;
      end
      tk         = ((n + 1) % div) == 0;
      i_tick     = tk;
      i_tx_start = spur && ($urandom_range(0, 15) == 0);
      i_data     = 8'($urandom);
      @(posedge i_clock);
      n++;
      if (tk) t++;
    end
  endtask

  task automatic idle_check(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      i_tx_start = 1'b0;
      i_tick     = 1'($urandom);
      i_data     = 8'($urandom);
      @(negedge i_clock);
      check("idle_tx", o_tx, 1'b1);
      check("idle_busy", o_busy, 1'b0);
      check("idle_done", o_tx_done_tick, 1'b0);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         chain;
    logic [7:0] next;
    int         exp_clocks;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int  de;
    bit  chained;

    tbl[0] = '{8'hBD, 1, 1'b1, 8'h81, CLK_D1};
    tbl[1] = '{8'h81, 1, 1'b0, 8'h00, CLK_D1};
    tbl[2] = '{8'h0F, 4, 1'b0, 8'h00, CLK_D4};
    tbl[3] = '{8'h55, 2, 1'b0, 8'h00, CLK_D2};
    tbl[4] = '{8'h01, 1, 1'b1, 8'hBD, CLK_D1};
    tbl[5] = '{8'hBD, 1, 1'b0, 8'h00, CLK_D1};
    tbl[6] = '{8'hFF, 1, 1'b0, 8'h00, CLK_D1};

    // Asynchronous reset before any clock edge
    #1 i_reset = 1'b0;
    #2;
    check("rst_tx", o_tx, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_tx_done_tick, 1'b0);
    i_tx_start = 1'b1;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check("rst_hold_tx", o_tx, 1'b1);
    check("rst_hold_busy", o_busy, 1'b0);
    i_tx_start = 1'b0;
    i_reset    = 1'b1;
    idle_check(4);

    chained = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!chained) begin
        i_tx_start = 1'b1;
        i_data     = tbl[i].data;
      end
      run_frame(tbl[i].data, tbl[i].div, 1'b1, tbl[i].chain, tbl[i].next, de);
      check_int("frame_clocks", de, tbl[i].exp_clocks);
      chained = tbl[i].chain;
      if (!chained) idle_check(3);
    end

    // Reset during data bit 4 aborts at once, and no done pulse follows
    i_tx_start = 1'b1;
    i_data     = 8'hBD;
    @(posedge i_clock);
    @(negedge i_clock);
    i_tx_start = 1'b0;
    i_tick     = 1'b1;
    repeat (16 + 16 * 4 + 8) @(posedge i_clock);
    #2;
    check("mid_busy_before", o_busy, 1'b1);
    i_reset = 1'b0;
    #1;
    check("mid_rst_tx", o_tx, 1'b1);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_done", o_tx_done_tick, 1'b0);
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    idle_check(FRAME_TICKS + 20);

    // Randomized frames with random tick rate, spurious starts and chaining
    chained = 1'b0;
    for (int r = 0; r < 10; r++) begin
      logic [7:0] d;
      logic [7:0] nd;
      int         div;
      bit         ch;
      if (chained) d = i_data;
      else d = 8'($urandom);
      nd  = 8'($urandom);
      div = $urandom_range(1, 4);
      ch  = (r != 9) && $urandom_range(0, 1) == 1;
      if (!chained) begin
        i_tx_start = 1'b1;
        i_data     = d;
      end
      run_frame(d, div, 1'b1, ch, nd, de);
      check_int("rand_frame_clocks", de, FRAME_TICKS * div);
      chained = ch;
      if (!chained) idle_check(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_uart.md
TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 SHALL have parameter NB_STATE, default 3, meaning state register width.
REQ-002 SHALL have parameter NB_COUNT, default 4, meaning tick counter width (16 ticks per bit).
REQ-003 SHALL have parameter NB_DATA_COUNT, default 4, meaning data-bit counter width.
REQ-004 SHALL have parameter NB_DATA, default 8, meaning payload bits per frame.
REQ-005 SHALL have parameter N_STOP_BITS, default 2, meaning stop bits per frame.
REQ-006 SHALL have port i_clock, input, 1, the single clock.
REQ-007 SHALL have port i_reset, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port i_tick, input, 1, oversampling tick enable, 16 ticks per bit; tied 1 means one tick per clock.
REQ-009 SHALL have port i_tx_start, input, 1, transmit request.
REQ-010 SHALL have port i_data, input, NB_DATA, payload.
REQ-011 SHALL have port o_tx, output, 1, serial line, idle high.
REQ-012 SHALL have port o_tx_done_tick, output, 1, one-clock frame-complete pulse.
REQ-013 SHALL have port o_busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when TX_PARITY_EN is defined.
REQ-015 In IDLE, i_tx_start=1 at a clock edge SHALL latch i_data into a shift register, clear the counters and enter START.
REQ-016 i_tx_start outside IDLE SHALL be ignored; i_data changes after acceptance SHALL NOT affect the frame.
REQ-017 o_tx SHALL be registered: low from the cycle after acceptance; the line is never combinationally driven from inputs.
REQ-018 Each bit SHALL last exactly 16 i_tick pulses; the tick counter advances only when i_tick=1 and wraps 15->0 at each bit boundary.
REQ-019 DATA SHALL shift payload LSB first; leave DATA after NB_DATA bits.
REQ-020 STOP SHALL drive o_tx=1 for N_STOP_BITS*16 ticks, then return to IDLE.
REQ-021 o_tx_done_tick SHALL be high for exactly the first IDLE cycle after STOP; i_tx_start in that cycle SHALL be accepted (zero idle gap).
REQ-022 With i_tick tied 1 and parity disabled, a frame SHALL occupy (1+NB_DATA+N_STOP_BITS)*16 clocks (176 at defaults).
REQ-023 Illegal state encodings SHALL recover to IDLE with o_tx=1.

Reset
REQ-024 While i_reset=0, regardless of clock: state=IDLE, o_tx=1, o_busy=0, o_tx_done_tick=0, counters and shift register=0.
REQ-025 Reset mid-frame SHALL abort the frame immediately; no done pulse SHALL follow.

Configuration
REQ-026 Macro TX_PARITY_EN defined: an even-parity bit (XOR of payload) SHALL be sent for 16 ticks between DATA and STOP; frame is 192 clocks at defaults.
REQ-027 Macro TX_PARITY_EN undefined: DATA SHALL go directly to STOP; no parity logic SHALL be synthesized.

Structure
REQ-028 State encodings, ticks-per-bit constant (16) and default widths SHALL live in shared package uart_pkg, also used by rx_uart.
REQ-029 No sub-module; the baud tick generator remains external and drives i_tick.

Verification (i_tick=1 unless stated, parity off unless stated)
REQ-030 Send 0xBD -> o_tx low 16 clocks, then 1,0,1,1,1,1,0,1 each 16 clocks, high 32 clocks; o_tx_done_tick single pulse at clock 177 after acceptance.
REQ-031 Hold i_tx_start during done cycle with 0x81 -> second start bit begins the next clock, no idle gap; loopback into rx_uart yields 0xBD then 0x81.
REQ-032 Pulse i_tx_start with 0x55 in mid-DATA of a 0xBD frame and toggle i_data -> transmitted waveform remains 0xBD; no extra frame.
REQ-033 Drive i_reset=0 during bit 4 of DATA -> o_tx=1, o_busy=0 immediately (asynchronous); no o_tx_done_tick after release.
REQ-034 i_tick every 4th clock, send 0x0F -> each bit lasts 64 clocks; frame 704 clocks.
REQ-035 With TX_PARITY_EN, send 0x01 -> parity bit 1; send 0xBD -> parity bit 0; done pulse at clock 193.
